// File: rtl/bm_arbiter.sv
// Arbitrates one single-port block memory between instruction fetch and data access.
// Data has priority with a streak limit; sub-word stores become read-modify-write sequences.
module bm_arbiter #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned MAX_DSTREAK = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_req,
   input  logic [31:0]           i_addr,
   output logic                  i_addr_ok,
   output logic                  i_data_ok,
   output logic [DATA_WIDTH-1:0] i_rdata,
   input  logic                  d_req,
   input  logic                  d_wr,
   input  logic [1:0]            d_size,
   input  logic [31:0]           d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic                  d_addr_ok,
   output logic                  d_data_ok,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  bm_ena,
   output logic                  bm_wea,
   output logic [ADDR_WIDTH-1:0] bm_addra,
   output logic [DATA_WIDTH-1:0] bm_dina,
   input  logic [DATA_WIDTH-1:0] bm_douta
);

   localparam int unsigned StreakW = $clog2(MAX_DSTREAK + 1);
   localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_DSTREAK);

   typedef enum logic [0:0] {StIdle, StRmw} state_e;

   state_e                  state_q, state_d;
   logic [StreakW-1:0]      streak_q, streak_d;
   logic                    resp_valid_q, resp_valid_d;
   logic                    resp_data_q, resp_data_d;
   logic                    resp_load_q, resp_load_d;
   logic [ADDR_WIDTH-1:0]   rmw_addr_q, rmw_addr_d;
   logic                    rmw_half_q, rmw_half_d;
   logic [1:0]              rmw_lane_q, rmw_lane_d;
   logic [15:0]             rmw_wdata_q, rmw_wdata_d;

   logic                    d_win, i_win, d_sub;
   logic [DATA_WIDTH-1:0]   merged;
   logic                    unused_bits;

   assign unused_bits = ^{i_addr[31:ADDR_WIDTH+2], i_addr[1:0], d_addr[31:ADDR_WIDTH+2]};
   assign d_sub       = d_wr && !d_size[1];

   // Grants are suppressed while in reset so every output reads 0.
   always_comb begin
      d_win = 1'b0;
      i_win = 1'b0;
      if (rst && state_q == StIdle) begin
         d_win = d_req && (!i_req || streak_q < StreakMax);
         i_win = i_req && !d_win;
      end
   end

   always_comb begin
      merged = bm_douta;
      if (rmw_half_q) begin
         merged[{rmw_lane_q[1], 4'b0000} +: 16] = rmw_wdata_q;
      end else begin
         merged[{rmw_lane_q, 3'b000} +: 8] = rmw_wdata_q[7:0];
      end
   end

   always_comb begin
      bm_ena   = 1'b0;
      bm_wea   = 1'b0;
      bm_addra = '0;
      bm_dina  = '0;
      if (rst && state_q == StRmw) begin
         bm_ena   = 1'b1;
         bm_wea   = 1'b1;
         bm_addra = rmw_addr_q;
         bm_dina  = merged;
      end else if (d_win) begin
         bm_ena   = 1'b1;
         bm_wea   = d_wr && d_size[1];
         bm_addra = d_addr[ADDR_WIDTH+1:2];
         bm_dina  = d_wdata;
      end else if (i_win) begin
         bm_ena   = 1'b1;
         bm_addra = i_addr[ADDR_WIDTH+1:2];
      end
   end

   always_comb begin
      state_d      = StIdle;
      streak_d     = streak_q;
      resp_valid_d = i_win || (d_win && !d_sub) || (state_q == StRmw);
      resp_data_d  = d_win || (state_q == StRmw);
      resp_load_d  = d_win && !d_wr;
      rmw_addr_d   = rmw_addr_q;
      rmw_half_d   = rmw_half_q;
      rmw_lane_d   = rmw_lane_q;
      rmw_wdata_d  = rmw_wdata_q;

      if (d_win && d_sub) begin
         state_d     = StRmw;
         rmw_addr_d  = d_addr[ADDR_WIDTH+1:2];
         rmw_half_d  = d_size[0];
         rmw_lane_d  = d_addr[1:0];
         rmw_wdata_d = d_wdata[15:0];
      end

      // The RMW cycle holds the streak, so a whole sub-word store counts once.
      if (!i_req || i_win) begin
         streak_d = '0;
      end else if (d_win && streak_q < StreakMax) begin
         streak_d = streak_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         streak_q     <= '0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= 1'b0;
         resp_load_q  <= 1'b0;
         rmw_addr_q   <= '0;
         rmw_half_q   <= 1'b0;
         rmw_lane_q   <= '0;
         rmw_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         streak_q     <= streak_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_load_q  <= resp_load_d;
         rmw_addr_q   <= rmw_addr_d;
         rmw_half_q   <= rmw_half_d;
         rmw_lane_q   <= rmw_lane_d;
         rmw_wdata_q  <= rmw_wdata_d;
      end
   end

   assign i_addr_ok = i_win;
   assign d_addr_ok = d_win;
   assign i_data_ok = resp_valid_q && !resp_data_q;
   assign d_data_ok = resp_valid_q && resp_data_q;
   assign i_rdata   = i_data_ok ? bm_douta : '0;
   assign d_rdata   = (d_data_ok && resp_load_q) ? bm_douta : '0;

endmodule

// File: tb/tb_bm_arbiter.sv
// Directed bench for bm_arbiter with a behavioural single-port block memory.
module tb_bm_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, d_req, d_wr;
   logic [31:0] i_addr, d_addr, d_wdata;
   logic [1:0]  d_size;
   logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
   logic [31:0] i_rdata, d_rdata;
   logic        bm_ena, bm_wea;
   logic [9:0]  bm_addra;
   logic [31:0] bm_dina;
   logic [31:0] bm_douta = 32'h0;

   logic [31:0] mem [1024];
   int          cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   bm_arbiter #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (10),
      .MAX_DSTREAK(4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .i_req    (i_req),
      .i_addr   (i_addr),
      .i_addr_ok(i_addr_ok),
      .i_data_ok(i_data_ok),
      .i_rdata  (i_rdata),
      .d_req    (d_req),
      .d_wr     (d_wr),
      .d_size   (d_size),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_addr_ok(d_addr_ok),
      .d_data_ok(d_data_ok),
      .d_rdata  (d_rdata),
      .bm_ena   (bm_ena),
      .bm_wea   (bm_wea),
      .bm_addra (bm_addra),
      .bm_dina  (bm_dina),
      .bm_douta (bm_douta)
   );

   // Memory contents are loaded on the first edge only, so a later reset leaves them alone.
   always @(posedge clk) begin
      if (cyc == 0) begin
         mem[1] <= 32'h0000_0001;
         mem[2] <= 32'h0000_0002;
         mem[3] <= 32'hAABB_CCDD;
         mem[4] <= 32'h0000_0000;
         mem[5] <= 32'h1234_5678;
         mem[7] <= 32'hFFFF_FFFF;
      end else if (bm_ena) begin
         if (bm_wea) mem[bm_addra] <= bm_dina;
         bm_douta <= mem[bm_addra];
      end
      cyc <= cyc + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // flags = {i_addr_ok, d_addr_ok, i_data_ok, d_data_ok, bm_ena, bm_wea}; req = {i_req, d_req, d_wr}
   typedef struct {
      logic [2:0]  req;
      logic [1:0]  size;
      logic [31:0] i_addr;
      logic [31:0] d_addr;
      logic [31:0] wdata;
      logic [5:0]  flags;
      logic [31:0] rdata;
      logic [9:0]  addra;
      logic [31:0] dina;
   } vec_t;

   vec_t vecs [22];

   task automatic run_vec(input int k, input vec_t v);
      {i_req, d_req, d_wr} = v.req;
      d_size  = v.size;
      i_addr  = v.i_addr;
      d_addr  = v.d_addr;
      d_wdata = v.wdata;
      @(negedge clk);
      chk($sformatf("v%0d flags", k),
          32'({i_addr_ok, d_addr_ok, i_data_ok, d_data_ok, bm_ena, bm_wea}), 32'(v.flags));
      chk($sformatf("v%0d i_rdata", k), i_rdata, v.flags[3] ? v.rdata : 32'h0);
      chk($sformatf("v%0d d_rdata", k), d_rdata, v.flags[2] ? v.rdata : 32'h0);
      if (v.flags[1]) chk($sformatf("v%0d bm_addra", k), 32'(bm_addra), 32'(v.addra));
      if (v.flags[0]) chk($sformatf("v%0d bm_dina", k), bm_dina, v.dina);
      @(posedge clk);
      #1;
   endtask

   logic exp_d, prev_d;

   initial begin
      vecs[0]  = '{3'b100, 2'd0, 32'hFFFF_F014, 32'h0, 32'h0, 6'b100010, 32'h0, 10'd5, 32'h0};
      vecs[1]  = '{3'b000, 2'd0, 32'h0, 32'h0, 32'h0, 6'b001000, 32'h1234_5678, 10'd0, 32'h0};
      vecs[2]  = '{3'b011, 2'd0, 32'h0, 32'h0E, 32'h11, 6'b010010, 32'h0, 10'd3, 32'h0};
      vecs[3]  = '{3'b000, 2'd0, 32'h0, 32'h0, 32'h0, 6'b000011, 32'h0, 10'd3, 32'hAA11_CCDD};
      vecs[4]  = '{3'b000, 2'd0, 32'h0, 32'h0, 32'h0, 6'b000100, 32'h0, 10'd0, 32'h0};
      vecs[5]  = '{3'b011, 2'd1, 32'h0, 32'h0C, 32'h5566, 6'b010010, 32'h0, 10'd3, 32'h0};
      vecs[6]  = '{3'b000, 2'd0, 32'h0, 32'h0, 32'h0, 6'b000011, 32'h0, 10'd3, 32'hAA11_5566};
      vecs[7]  = '{3'b010, 2'd2, 32'h0, 32'h0C, 32'h0, 6'b010110, 32'h0, 10'd3, 32'h0};
      vecs[8]  = '{3'b000, 2'd0, 32'h0, 32'h0, 32'h0, 6'b000100, 32'hAA11_5566, 10'd0, 32'h0};
      vecs[9]  = '{3'b100, 2'd0, 32'h4, 32'h0, 32'h0, 6'b100010, 32'h0, 10'd1, 32'h0};
      vecs[10] = '{3'b010, 2'd2, 32'h0, 32'h8, 32'h0, 6'b011010, 32'h1, 10'd2, 32'h0};
      vecs[11] = '{3'b100, 2'd0, 32'h4, 32'h0, 32'h0, 6'b100110, 32'h2, 10'd1, 32'h0};
      vecs[12] = '{3'b010, 2'd2, 32'h0, 32'h8, 32'h0, 6'b011010, 32'h1, 10'd2, 32'h0};
      vecs[13] = '{3'b111, 2'd0, 32'h8, 32'h4, 32'hAB, 6'b010110, 32'h2, 10'd1, 32'h0};
      vecs[14] = '{3'b100, 2'd0, 32'h8, 32'h0, 32'h0, 6'b000011, 32'h0, 10'd1, 32'h0000_00AB};
      vecs[15] = '{3'b100, 2'd0, 32'h8, 32'h0, 32'h0, 6'b100110, 32'h0, 10'd2, 32'h0};
      vecs[16] = '{3'b010, 2'd2, 32'h0, 32'h4, 32'h0, 6'b011010, 32'h2, 10'd1, 32'h0};
      vecs[17] = '{3'b000, 2'd0, 32'h0, 32'h0, 32'h0, 6'b000100, 32'h0000_00AB, 10'd0, 32'h0};
      vecs[18] = '{3'b011, 2'd2, 32'h0, 32'h8000_1013, 32'hCAFE_F00D, 6'b010011, 32'h0, 10'd4,
                   32'hCAFE_F00D};
      vecs[19] = '{3'b010, 2'd2, 32'h0, 32'h10, 32'h0, 6'b010110, 32'h0, 10'd4, 32'h0};
      vecs[20] = '{3'b000, 2'd0, 32'h0, 32'h0, 32'h0, 6'b000100, 32'hCAFE_F00D, 10'd0, 32'h0};
      vecs[21] = '{3'b000, 2'd0, 32'h0, 32'h0, 32'h0, 6'b000000, 32'h0, 10'd0, 32'h0};

      // Reset held with both requesters active: everything must stay 0.
      rst = 1'b0;
      i_req = 1'b1; i_addr = 32'h8;
      d_req = 1'b1; d_wr = 1'b0; d_size = 2'd2; d_addr = 32'h4; d_wdata = 32'h0;
      for (int r = 0; r < 3; r++) begin
         @(negedge clk);
         chk($sformatf("rst%0d flags", r),
             32'({i_addr_ok, d_addr_ok, i_data_ok, d_data_ok, bm_ena, bm_wea}), 32'h0);
         chk($sformatf("rst%0d addra", r), 32'(bm_addra), 32'h0);
         chk($sformatf("rst%0d dina", r), bm_dina, 32'h0);
         chk($sformatf("rst%0d rdata", r), i_rdata | d_rdata, 32'h0);
         @(posedge clk);
         #1;
      end
      rst = 1'b1;

      // Both held: D,D,D,D,I repeating; each grant answered the next cycle.
      prev_d = 1'b0;
      for (int c = 0; c < 11; c++) begin
         if (c == 10) begin
            i_req = 1'b0;
            d_req = 1'b0;
         end
         @(negedge clk);
         exp_d = (c % 5) != 4;
         chk($sformatf("streak%0d one_grant", c), 32'(i_addr_ok & d_addr_ok), 32'h0);
         if (c < 10) begin
            chk($sformatf("streak%0d d_addr_ok", c), 32'(d_addr_ok), 32'(exp_d));
            chk($sformatf("streak%0d i_addr_ok", c), 32'(i_addr_ok), 32'(!exp_d));
         end else begin
            chk("streak idle grant", 32'({i_addr_ok, d_addr_ok}), 32'h0);
         end
         if (c > 0) begin
            chk($sformatf("streak%0d d_data_ok", c), 32'(d_data_ok), 32'(prev_d));
            chk($sformatf("streak%0d i_data_ok", c), 32'(i_data_ok), 32'(!prev_d));
            chk($sformatf("streak%0d rdata", c), prev_d ? d_rdata : i_rdata,
                prev_d ? 32'h1 : 32'h2);
         end
         prev_d = exp_d;
         @(posedge clk);
         #1;
      end

      for (int k = 0; k < 22; k++) run_vec(k, vecs[k]);

      // Reset asserted during the merge-write cycle of a byte store.
      d_req = 1'b1; d_wr = 1'b1; d_size = 2'd0; d_addr = 32'h1C; d_wdata = 32'h0;
      @(negedge clk);
      chk("rmwrst grant", 32'(d_addr_ok), 32'h1);
      @(posedge clk);
      #1;
      d_req = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("rmwrst wea", 32'({bm_ena, bm_wea}), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("rmwrst no_ok%0d", c), 32'({d_data_ok, i_data_ok}), 32'h0);
         @(posedge clk);
         #1;
      end
      d_req = 1'b1; d_wr = 1'b0; d_size = 2'd2; d_addr = 32'h1C;
      @(negedge clk);
      chk("rmwrst load grant", 32'(d_addr_ok), 32'h1);
      @(posedge clk);
      #1;
      d_req = 1'b0;
      @(negedge clk);
      chk("rmwrst load ok", 32'(d_data_ok), 32'h1);
      chk("rmwrst word7", d_rdata, 32'hFFFF_FFFF);
      @(posedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
